// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - Frame-buffer RAM arbiter: display reads take priority, host writes fill the idle clocks.
// Optional FB_ADDR_CHECK_EN: drop out-of-range host writes and pulse wr_err.
module vga_fb_arbiter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_tick,
    input  logic              disp_active,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;

    if (FB_SIZE > (1 << ADDR_W)) begin : g_addr_w_check
        $error("ADDR_W too small for frame buffer");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_RD  = 2'd1,
        DISP_CAP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic [9:0]        fb_x;
    logic [9:0]        fb_y;
    logic [ADDR_W-1:0] lin_addr;
    logic              disp_tick;
    logic              blank_tick;
    logic              wr_fire;
    logic              wr_in_range;

    assign disp_tick  = pix_tick && disp_active;
    assign blank_tick = pix_tick && !disp_active;

    assign fb_x     = disp_x >> SCALE_SHIFT;
    assign fb_y     = disp_y >> SCALE_SHIFT;
    assign lin_addr = ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x);

    // Host may only use the RAM when no read is in flight and no new read starts this clk.
    assign wr_ready = !rst && (state == IDLE || state == DISP_CAP) && !disp_tick;
    assign wr_fire  = wr_valid && wr_ready;

`ifdef FB_ADDR_CHECK_EN
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);

    assign wr_in_range = (wr_addr <= FB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_fire && !wr_in_range;
        end
    end
`else
    assign wr_in_range = 1'b1;
    assign wr_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_addr <= '0;
        end else begin
            state <= state_next;
            if (load_rd) begin
                rd_addr <= lin_addr;
            end
        end
    end

    // Blanking beats a capture landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {red, green, blue} <= 12'h000;
        end else if (state == DISP_CAP) begin
            {red, green, blue} <= blank_tick ? 12'h000 : mem_rdata;
        end else if (state == IDLE && blank_tick) begin
            {red, green, blue} <= 12'h000;
        end
    end

    always_comb begin
        state_next = state;
        load_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (disp_tick) begin
                    state_next = DISP_RD;
                    load_rd    = 1'b1;
                end
            end
            DISP_RD: begin
                state_next = DISP_CAP;
            end
            DISP_CAP: begin
                state_next = disp_tick ? DISP_RD : IDLE;
                load_rd    = disp_tick;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state == DISP_RD) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end else if (wr_fire && wr_in_range) begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - Scoreboard bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_tick;
    logic        disp_active;
    logic [9:0]  disp_x;
    logic [9:0]  disp_y;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        wr_err;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .disp_active(disp_active),
        .disp_x(disp_x), .disp_y(disp_y), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    logic [11:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit we; logic [14:0] addr; logic [11:0] data; } mem_t;
    typedef struct { int due; logic [11:0] rgb; } pix_t;
    mem_t mq[$];
    pix_t pq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_read(input logic [14:0] a);
        mq.push_back('{we: 1'b0, addr: a, data: 12'h000});
    endtask

    task automatic exp_write(input logic [14:0] a, input logic [11:0] d);
        mq.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    task automatic exp_pix(input int due, input logic [11:0] v);
        pq.push_back('{due: due, rgb: v});
    endtask

    // Monitor: every RAM access must match the head of the expected queue; pixels are checked on their due clk.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_en === 1'b1) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_access", {4'h0, mem_we, mem_addr, mem_wdata}, 32'h0);
                end else begin
                    mem_t e;
                    e = mq.pop_front();
                    check("mem_access", {4'h0, mem_we, mem_addr, (mem_we ? mem_wdata : 12'h000)},
                          {4'h0, e.we, e.addr, (e.we ? e.data : 12'h000)});
                end
            end
            while (pq.size() != 0 && pq[0].due <= cyc) begin
                pix_t p;
                p = pq.pop_front();
                check("pixel_rgb", {20'h0, red, green, blue}, {20'h0, p.rgb});
            end
        end
    end

    task automatic drive(input bit tick, input bit act, input int x, input int y);
        @(posedge clk);
        #1;
        pix_tick    = tick;
        disp_active = act;
        disp_x      = 10'(x);
        disp_y      = 10'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic host_write(input logic [14:0] a, input logic [11:0] d, input bit expect_mem);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        forever begin
            @(negedge clk);
            if (wr_ready === 1'b1 || waited > 16) break;
            waited++;
            @(posedge clk);
            #1;
        end
        check("wr_accept", {31'h0, wr_ready}, 32'h1);
        if (wr_ready === 1'b1 && expect_mem) exp_write(a, d);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int nacc;
        rst = 1'b1; pix_tick = 1'b0; disp_active = 1'b0; disp_x = '0; disp_y = '0;
        wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 12'h777;

        // Reset with a pending write: nothing may reach the RAM.
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
            check("rst_mem_en", {31'h0, mem_en}, 32'h0);
            check("rst_rgb", {20'h0, red, green, blue}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle_ready", {31'h0, wr_ready}, 32'h1);
        check("post_rst_wr_err", {31'h0, wr_err}, 32'h0);

        host_write(15'd321, 12'hF0A, 1'b1);
        host_write(15'd0, 12'h111, 1'b1);
        host_write(15'd1, 12'h222, 1'b1);
        host_write(15'd2, 12'h333, 1'b1);
        idle(2);

        // (5,9) -> (9>>2)*160 + (5>>2) = 321
        drive(1'b1, 1'b1, 5, 9);
        c0 = cyc;
        exp_read(15'd321);
        exp_pix(c0 + 3, 12'hF0A);
        drive(1'b0, 1'b1, 0, 0);
        drive(1'b0, 1'b1, 0, 0);
        @(negedge clk);
        check("map_rgb_not_yet", {20'h0, red, green, blue}, 32'h0);
        drive(1'b0, 1'b1, 0, 0);
        @(negedge clk);
        check("map_red", {28'h0, red}, 32'hF);
        check("map_green", {28'h0, green}, 32'h0);
        check("map_blue", {28'h0, blue}, 32'hA);
        idle(3);

        // Continuous host traffic against ticks every 4 clk.
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            pix_tick    = (c % 4 == 0);
            disp_active = 1'b1;
            disp_x      = 10'(4 * (c / 4));
            disp_y      = 10'd0;
            wr_valid    = 1'b1;
            wr_addr     = 15'(1000 + nacc);
            wr_data     = 12'(12'h800 + nacc);
            if (c % 4 == 0) begin
                exp_read(15'(c / 4));
                exp_pix(cyc + 3, 12'(12'h111 * (c / 4 + 1)));
            end
            @(negedge clk);
            check("arb_wr_ready", {31'h0, wr_ready}, {31'h0, (c % 4 >= 2)});
            if (c % 4 == 1) check("arb_no_we_in_rd", {31'h0, mem_we}, 32'h0);
            if (wr_ready === 1'b1) begin
                exp_write(15'(1000 + nacc), 12'(12'h800 + nacc));
                nacc++;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        pix_tick = 1'b0;
        check("arb_write_count", nacc, 6);
        idle(2);

        // Blank tick after a lit pixel.
        drive(1'b1, 1'b0, 0, 0);
        exp_pix(cyc + 1, 12'h000);
        idle(2);
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            wr_valid = 1'b1;
            wr_addr  = 15'(2000 + i);
            wr_data  = 12'(12'h0A0 + i);
            @(negedge clk);
            check("blank_wr_ready", {31'h0, wr_ready}, 32'h1);
            if (wr_ready === 1'b1) begin
                exp_write(15'(2000 + i), 12'(12'h0A0 + i));
                nacc++;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check("blank_write_count", nacc, 10);

        // Last frame-buffer word.
        host_write(15'd19199, 12'h5A5, 1'b1);
        @(negedge clk);
        check("inrange_wr_err", {31'h0, wr_err}, 32'h0);
        idle(1);
        drive(1'b1, 1'b1, 639, 479);
        exp_read(15'd19199);
        exp_pix(cyc + 3, 12'h5A5);
        idle(5);

`ifdef FB_ADDR_CHECK_EN
        host_write(15'd19200, 12'hBAD, 1'b0);
        @(negedge clk);
        check("oob_wr_err_pulse", {31'h0, wr_err}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("oob_wr_err_clear", {31'h0, wr_err}, 32'h0);
`else
        host_write(15'd19200, 12'hBAD, 1'b1);
        @(negedge clk);
        check("oob_wr_err_tied", {31'h0, wr_err}, 32'h0);
`endif
        idle(2);

        // Second tick lands in DISP_CAP: capture then immediate re-read.
        drive(1'b1, 1'b1, 5, 9);
        c0 = cyc;
        exp_read(15'd321);
        exp_pix(c0 + 3, 12'hF0A);
        drive(1'b0, 1'b1, 0, 0);
        @(negedge clk);
        check("cap_ready_in_rd", {31'h0, wr_ready}, 32'h0);
        drive(1'b1, 1'b1, 639, 479);
        exp_read(15'd19199);
        exp_pix(c0 + 5, 12'h5A5);
        @(negedge clk);
        check("cap_ready_on_tick", {31'h0, wr_ready}, 32'h0);
        idle(5);

        // Tick landing in DISP_RD is ignored.
        drive(1'b1, 1'b1, 5, 9);
        c0 = cyc;
        exp_read(15'd321);
        exp_pix(c0 + 3, 12'hF0A);
        exp_pix(c0 + 4, 12'hF0A);
        drive(1'b1, 1'b1, 639, 479);
        @(negedge clk);
        check("ign_ready_in_rd", {31'h0, wr_ready}, 32'h0);
        idle(6);

        check("mem_queue_drained", mq.size(), 0);
        check("pix_queue_drained", pq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
